// File: rtl/multi_timer_if.sv
// multi_timer_if: byte-wide register bus and interrupt line of the multi_timer block.
// Ports: addr (16-bit byte address), we (write strobe), di (write data),
//        dout (combinational read data), irq (level interrupt).
// The read-data signal is named dout because "do" is a SystemVerilog keyword.
interface multi_timer_if;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  di;
  logic [7:0]  dout;
  logic        irq;

  // master: the bus host issuing reads/writes; slave: the timer block.
  modport master (output addr, output we, output di, input dout, input irq);
  modport slave  (input addr, input we, input di, output dout, output irq);
endinterface

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH independent up-counting timer channels behind a byte-wide register bus.
// Ports: clk, rst (async, active-high), bus (multi_timer_if.slave: addr/we/di in, dout/irq out).
// Optional feature: define MULTI_TIMER_PRESCALE_EN to add a shared 8-bit tick prescaler
// at BASE_ADDR+8*NUM_CH; without it every clock is a tick and that address reads 0.
//
// Per-channel map (BASE_ADDR + 8*c + offset):
//   0..3 reload bytes (LSB first), 4 control {irq_en,periodic,en}, 5 status {flag},
//   6 live count byte 0 (read-only), 7 restart (any write).
module multi_timer #(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter logic [15:0] BASE_ADDR  = 16'hFF40,
  parameter logic [31:0] RST_RELOAD = 32'd5000000
) (
  input logic           clk,
  input logic           rst,
  multi_timer_if.slave  bus
);

  localparam int              NB       = CNT_W / 8;
  localparam logic [CNT_W-1:0] RST_RL  = RST_RELOAD[CNT_W-1:0];
  localparam logic [15:0]     MAP_SPAN = 16'(8 * NUM_CH);

  // ---------------------------------------------------------------------------
  // Address decode. Addresses below BASE_ADDR wrap to a large offset and so
  // fall outside the channel window.
  // ---------------------------------------------------------------------------
  logic [15:0] off;
  logic        in_ch;
  logic [2:0]  sel_ch;
  logic [2:0]  sel_reg;

  assign off     = bus.addr - BASE_ADDR;
  assign in_ch   = (off < MAP_SPAN);
  assign sel_ch  = off[5:3];
  assign sel_reg = off[2:0];

  // ---------------------------------------------------------------------------
  // Tick source
  // ---------------------------------------------------------------------------
  logic tick;

`ifdef MULTI_TIMER_PRESCALE_EN
  logic [7:0] presc_reg;
  logic [7:0] presc_cnt;
  logic       presc_wr;

  assign presc_wr = bus.we && (off == MAP_SPAN);
  // Counter runs 0..presc_reg, so a value P yields one tick every P+1 clocks.
  // If the register is lowered below the running count, the counter wraps
  // through 255 once before settling into the new period.
  assign tick     = (presc_cnt == presc_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= 8'h00;
      presc_cnt <= 8'h00;
    end else begin
      if (presc_wr) presc_reg <= bus.di;
      if (tick) presc_cnt <= 8'h00;
      else      presc_cnt <= presc_cnt + 8'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  // ch_rd[c] holds the eight readable bytes of channel c, byte 0 in the LSBs.
  logic [NUM_CH-1:0][63:0] ch_rd;
  logic [NUM_CH-1:0]       flag_v;
  logic [NUM_CH-1:0]       irq_en_v;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] reload_q;
    logic [CNT_W-1:0] count_q;
    logic             en_q;
    logic             per_q;
    logic             ie_q;
    logic             flag_q;

    logic             hit;
    logic             wr_ctrl;
    logic             wr_stat;
    logic             wr_rst;
    logic             trig;
    logic [31:0]      reload_32;

    assign hit     = bus.we && in_ch && (sel_ch == 3'(c));
    assign wr_ctrl = hit && (sel_reg == 3'd4);
    assign wr_stat = hit && (sel_reg == 3'd5) && bus.di[0];
    assign wr_rst  = hit && (sel_reg == 3'd7);
    // ">=" rather than "==" so a reload lowered beneath the live count still
    // fires on the next tick instead of waiting for a full wrap.
    assign trig    = en_q && tick && (count_q >= reload_q);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        reload_q <= RST_RL;
        count_q  <= '0;
        flag_q   <= 1'b0;
        en_q     <= (c == 0);
        per_q    <= (c == 0);
        ie_q     <= 1'b0;
      end else begin
        // Reload bytes above the counter width are not stored.
        for (int b = 0; b < NB; b++) begin
          if (hit && (sel_reg == 3'(b))) reload_q[8*b +: 8] <= bus.di;
        end

        // Count priority: restart, enable rising edge, trigger, disable
        // (freeze), then normal increment.
        if (wr_rst)
          count_q <= '0;
        else if (wr_ctrl && bus.di[0] && !en_q)
          count_q <= '0;
        else if (trig)
          count_q <= '0;
        else if (wr_ctrl && !bus.di[0])
          count_q <= count_q;
        else if (en_q && tick)
          count_q <= count_q + CNT_W'(1);

        // A trigger beats a coincident clear so no event is lost.
        if (trig)
          flag_q <= 1'b1;
        else if (wr_stat || wr_rst)
          flag_q <= 1'b0;

        // A control write beats the one-shot auto-disable.
        if (wr_ctrl) begin
          en_q  <= bus.di[0];
          per_q <= bus.di[1];
          ie_q  <= bus.di[2];
        end else if (trig && !per_q) begin
          en_q  <= 1'b0;
        end
      end
    end

    assign reload_32   = 32'(reload_q);
    assign ch_rd[c]    = {8'h00, count_q[7:0], 7'b0, flag_q, 5'b0, ie_q, per_q, en_q, reload_32};
    assign flag_v[c]   = flag_q;
    assign irq_en_v[c] = ie_q;
  end

  // ---------------------------------------------------------------------------
  // Read mux (combinational from addr)
  // ---------------------------------------------------------------------------
  logic [7:0]  rd_dat;
  logic [63:0] rd_word;

  always_comb begin
    rd_dat  = 8'h00;
    rd_word = 64'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_ch == 3'(c)) rd_word = ch_rd[c];
    end
    if (in_ch) begin
      for (int b = 0; b < 8; b++) begin
        if (sel_reg == 3'(b)) rd_dat = rd_word[8*b +: 8];
      end
    end
`ifdef MULTI_TIMER_PRESCALE_EN
    if (off == MAP_SPAN) rd_dat = presc_reg;
`endif
  end

  // Outputs are forced low during reset so they read 0 the instant rst rises.
  assign bus.dout = rst ? 8'h00 : rd_dat;
  assign bus.irq  = !rst && |(flag_v & irq_en_v);

endmodule
